// File: rtl/multi_insert_fifo_pkg.sv
// Shared types and helpers for the multi-insert compacting FIFO.
// entry_t is sized by DATA_WIDTH here; the top-level DATA_WIDTH must match it.
package multi_insert_fifo_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
  localparam int ENTRY_WIDTH = DATA_WIDTH + DATA_WIDTH / 8 + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
  } entry_t;

  // A lane carries a word whenever any byte of its keep group is set.
  function automatic logic lane_valid(input logic [KEEP_WIDTH-1:0] keep);
    return |keep;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/axi4s_if.sv
// Minimal AXI4-Stream bundle; the master side also carries the stream clock.
interface axi4s_if #(
  parameter int TDATA_WIDTH = 32
) ();
  logic                     aclk;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic                     tvalid;
  logic                     tready;

  // A beat transfers on the cycle where tvalid && tready; a master holds the
  // beat stable until then and tvalid never depends on tready.
  modport m (output aclk, output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport s (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/multi_insert_fifo_compact_lane_compactor.sv
// Combinational prefix-sum router: packs the valid input lanes of one beat into
// consecutive positions (ascending lane order) and reports how many there are.
module lane_compactor
  import multi_insert_fifo_pkg::*;
#(
  parameter  int IN_LANES = 4,
  localparam int NW       = $clog2(IN_LANES + 1)
) (
  input  logic [IN_LANES*DATA_WIDTH-1:0] tdata,
  input  logic [IN_LANES*KEEP_WIDTH-1:0] tkeep,
  input  logic                           tlast,
  output entry_t                         lanes [IN_LANES],
  output logic [NW-1:0]                  n_in
);

  logic [IN_LANES-1:0] valid;
  logic [IN_LANES-1:0] top_lane;
  logic                seen;
  int                  pos;

  always_comb begin
    valid    = '0;
    top_lane = '0;
    seen     = 1'b0;
    pos      = 0;
    for (int k = 0; k < IN_LANES; k++) begin
      lanes[k] = '0;
    end
    for (int i = 0; i < IN_LANES; i++) begin
      valid[i] = lane_valid(tkeep[i*KEEP_WIDTH +: KEEP_WIDTH]);
    end
    // tlast belongs to the highest valid lane only.
    for (int i = IN_LANES - 1; i >= 0; i--) begin
      top_lane[i] = valid[i] && !seen;
      seen        = seen || valid[i];
    end
    for (int i = 0; i < IN_LANES; i++) begin
      if (valid[i]) begin
        lanes[pos].data = tdata[i*DATA_WIDTH +: DATA_WIDTH];
        lanes[pos].keep = tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        lanes[pos].last = tlast && top_lane[i];
        pos             = pos + 1;
      end
    end
    n_in = NW'(popcount(32'(valid)));
  end

endmodule

// File: rtl/multi_insert_fifo_compact.sv
// Variable-yield stream FIFO: compacts up to IN_LANES words per input beat and
// emits OUT_LANES-wide beats, partial only at tlast. Optional sticky protocol
// checker enabled by defining MULTI_INSERT_FIFO_ERR_EN.
module multi_insert_fifo_compact #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IN_LANES   = 4,
  parameter int OUT_LANES  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  axi4s_if.s                       i_data,
  axi4s_if.m                       o_data,
  output logic [$clog2(DEPTH):0]   filling_level,
  output logic                     err
);
  import multi_insert_fifo_pkg::*;

  localparam int KW = DATA_WIDTH / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(IN_LANES + 1);
  localparam int OW = $clog2(OUT_LANES + 1);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  entry_t        lanes [IN_LANES];
  logic [NW-1:0] n_in;
  logic          in_ready;
  logic          push;

  entry_t        win [OUT_LANES];
  logic [OW-1:0] n_out;
  logic          has_last;
  logic          out_valid;
  logic          pop;

  logic [OUT_LANES*DATA_WIDTH-1:0] o_tdata;
  logic [OUT_LANES*KW-1:0]         o_tkeep;
  logic                            o_tlast;

  lane_compactor #(
    .IN_LANES (IN_LANES)
  ) u_compactor (
    .tdata (i_data.tdata),
    .tkeep (i_data.tkeep),
    .tlast (i_data.tlast),
    .lanes (lanes),
    .n_in  (n_in)
  );

  // Ready depends only on the stored count, so a beat of any yield always fits.
  assign in_ready      = !rst && (count_q <= CW'(DEPTH - IN_LANES));
  assign push          = i_data.tvalid && in_ready;
  assign i_data.tready = in_ready;

  always_comb begin
    has_last = 1'b0;
    n_out    = OW'(OUT_LANES);
    for (int j = 0; j < OUT_LANES; j++) begin
      win[j] = mem_q[rd_ptr_q + PW'(j)];
      if (!has_last && (CW'(j) < count_q) && win[j].last) begin
        has_last = 1'b1;
        n_out    = OW'(j + 1);
      end
    end
  end

  assign out_valid = (count_q >= CW'(OUT_LANES)) || has_last;
  assign pop       = out_valid && o_data.tready;

  always_comb begin
    o_tdata = '0;
    o_tkeep = '0;
    o_tlast = 1'b0;
    if (out_valid) begin
      for (int j = 0; j < OUT_LANES; j++) begin
        if (OW'(j) < n_out) begin
          o_tdata[j*DATA_WIDTH +: DATA_WIDTH] = win[j].data;
          o_tkeep[j*KW +: KW]                 = win[j].keep;
        end
      end
      o_tlast = has_last;
    end
  end

  assign o_data.aclk   = clk;
  assign o_data.tvalid = out_valid;
  assign o_data.tdata  = o_tdata;
  assign o_data.tkeep  = o_tkeep;
  assign o_data.tlast  = o_tlast;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      for (int k = 0; k < IN_LANES; k++) begin
        if (NW'(k) < n_in) begin
          mem_d[wr_ptr_q + PW'(k)] = lanes[k];
        end
      end
      wr_ptr_d = wr_ptr_q + PW'(n_in);
      count_d  = count_d + CW'(n_in);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(n_out);
      count_d  = count_d - CW'(n_out);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign filling_level = count_q;

`ifdef MULTI_INSERT_FIFO_ERR_EN
  logic                err_q, err_d;
  logic                bad_keep;
  logic                seen_hi;
  logic [IN_LANES-1:0] top_lane;

  always_comb begin
    bad_keep = 1'b0;
    seen_hi  = 1'b0;
    top_lane = '0;
    for (int i = IN_LANES - 1; i >= 0; i--) begin
      top_lane[i] = lane_valid(i_data.tkeep[i*KW +: KW]) && !seen_hi;
      seen_hi     = seen_hi || lane_valid(i_data.tkeep[i*KW +: KW]);
    end
    // Only the lane carrying tlast may hold a partial word.
    for (int i = 0; i < IN_LANES; i++) begin
      if (lane_valid(i_data.tkeep[i*KW +: KW]) && !(i_data.tlast && top_lane[i]) &&
          (i_data.tkeep[i*KW +: KW] != {KW{1'b1}})) begin
        bad_keep = 1'b1;
      end
    end
    err_d = err_q || (push && (n_in == '0) && i_data.tlast) || (i_data.tvalid && bad_keep);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_multi_insert_fifo_compact.sv
// Directed bench for multi_insert_fifo_compact (DEPTH=16, 4 lanes in, 2 lanes out).
module tb_multi_insert_fifo_compact;

`ifdef MULTI_INSERT_FIFO_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [4:0] fill;
  logic       err;

  axi4s_if #(.TDATA_WIDTH(128)) in_if ();
  axi4s_if #(.TDATA_WIDTH(64))  out_if ();

  assign in_if.aclk = clk;

  multi_insert_fifo_compact #(
    .DEPTH      (16),
    .DATA_WIDTH (32),
    .IN_LANES   (4),
    .OUT_LANES  (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_data        (in_if),
    .o_data        (out_if),
    .filling_level (fill),
    .err           (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [15:0]  keep;
    logic [127:0] data;
    logic         last;
    int           fill;
    int           nb;
    logic [63:0]  d0;
    logic [7:0]   k0;
    logic         l0;
    logic [63:0]  d1;
    logic [7:0]   k1;
    logic         l1;
    int           res;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] w4(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  function automatic vec_t mkv(input logic [15:0] keep, input logic [127:0] data, input logic last,
                               input int fill_v, input int nb,
                               input logic [63:0] d0, input logic [7:0] k0, input logic l0,
                               input logic [63:0] d1, input logic [7:0] k1, input logic l1,
                               input int res);
    vec_t v;
    v.keep = keep; v.data = data; v.last = last; v.fill = fill_v; v.nb = nb;
    v.d0 = d0; v.k0 = k0; v.l0 = l0; v.d1 = d1; v.k1 = k1; v.l1 = l1; v.res = res;
    return v;
  endfunction

  // driver tasks
  task automatic add_exp(input logic [15:0] keep, input logic [127:0] data);
    for (int i = 0; i < 4; i++) begin
      if (keep[i*4 +: 4] != 4'h0) exp_q.push_back(data[i*32 +: 32]);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic push(input logic [15:0] keep, input logic [127:0] data, input logic last);
    int guard;
    in_if.tdata  = data;
    in_if.tkeep  = keep;
    in_if.tlast  = last;
    in_if.tvalid = 1'b1;
    guard = 0;
    while (!in_if.tready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_if.tready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=tready0 required=tready1");
    end
    @(negedge clk);
    in_if.tvalid = 1'b0;
    in_if.tkeep  = '0;
    in_if.tlast  = 1'b0;
    add_exp(keep, data);
  endtask

  task automatic drain(input int cycles);
    logic [31:0] w;
    for (int c = 0; c < cycles; c++) begin
      if (out_if.tvalid && out_if.tready) begin
        for (int j = 0; j < 2; j++) begin
          if (out_if.tkeep[j*4 +: 4] != 4'h0) begin
            if (exp_q.size() == 0) begin
              chk("drain_extra_word", out_if.tdata[j*32 +: 32], 128'hx);
            end else begin
              w = exp_q.pop_front();
              chk("drain_word", out_if.tdata[j*32 +: 32], w);
            end
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    in_if.tdata  = v.data;
    in_if.tkeep  = v.keep;
    in_if.tlast  = v.last;
    in_if.tvalid = 1'b1;
    chk({tag, "_in_ready"}, in_if.tready, 1'b1);
    @(negedge clk);
    in_if.tvalid = 1'b0;
    in_if.tkeep  = '0;
    in_if.tlast  = 1'b0;
    chk({tag, "_fill_after_push"}, fill, v.fill);
    for (int b = 0; b < v.nb; b++) begin
      chk({tag, "_tvalid"}, out_if.tvalid, 1'b1);
      chk({tag, "_tdata"},  out_if.tdata,  (b == 0) ? v.d0 : v.d1);
      chk({tag, "_tkeep"},  out_if.tkeep,  (b == 0) ? v.k0 : v.k1);
      chk({tag, "_tlast"},  out_if.tlast,  (b == 0) ? v.l0 : v.l1);
      @(negedge clk);
    end
    chk({tag, "_idle_tvalid"}, out_if.tvalid, 1'b0);
    chk({tag, "_residual"}, fill, v.res);
  endtask

  initial begin
    vecs[0] = mkv(16'hFFFF, w4(32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003), 1'b0, 4, 2,
                  {32'hD000_0001, 32'hD000_0000}, 8'hFF, 1'b0,
                  {32'hD000_0003, 32'hD000_0002}, 8'hFF, 1'b0, 0);
    vecs[1] = mkv(16'hF0F0, w4(32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD), 1'b1, 2, 1,
                  {32'hDDDD_DDDD, 32'hBBBB_BBBB}, 8'hFF, 1'b1, 64'h0, 8'h00, 1'b0, 0);
    vecs[2] = mkv(16'h000F, w4(32'hEEEE_EEEE, 32'h1, 32'h2, 32'h3), 1'b1, 1, 1,
                  {32'h0, 32'hEEEE_EEEE}, 8'h0F, 1'b1, 64'h0, 8'h00, 1'b0, 0);
    vecs[3] = mkv(16'h000F, w4(32'h1111_1111, 32'h4, 32'h5, 32'h6), 1'b0, 1, 0,
                  64'h0, 8'h00, 1'b0, 64'h0, 8'h00, 1'b0, 1);
    vecs[4] = mkv(16'hFF00, w4(32'h7, 32'h8, 32'h2222_2222, 32'h3333_3333), 1'b1, 3, 2,
                  {32'h2222_2222, 32'h1111_1111}, 8'hFF, 1'b0,
                  {32'h0, 32'h3333_3333}, 8'h0F, 1'b1, 0);
    vecs[5] = mkv(16'h0000, w4(32'h9, 32'hA, 32'hB, 32'hC), 1'b1, 0, 0,
                  64'h0, 8'h00, 1'b0, 64'h0, 8'h00, 1'b0, 0);
    vecs[6] = mkv(16'h0F0F, w4(32'h4444_4444, 32'hD, 32'h5555_5555, 32'hE), 1'b0, 2, 1,
                  {32'h5555_5555, 32'h4444_4444}, 8'hFF, 1'b0, 64'h0, 8'h00, 1'b0, 0);

    rst           = 1'b1;
    in_if.tdata   = '0;
    in_if.tkeep   = '0;
    in_if.tlast   = 1'b0;
    in_if.tvalid  = 1'b0;
    out_if.tready = 1'b0;
    #1;
    chk("rst_fill",   fill,          0);
    chk("rst_tvalid", out_if.tvalid, 1'b0);
    chk("rst_tkeep",  out_if.tkeep,  8'h00);
    chk("rst_tlast",  out_if.tlast,  1'b0);
    chk("rst_err",    err,           1'b0);
    chk("rst_tready", in_if.tready,  1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_tready", in_if.tready, 1'b1);
    @(negedge clk);

    // table-driven single-beat vectors, output always ready
    out_if.tready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      apply_vec(i, vecs[i]);
    end
    chk("err_after_vectors", err, ERR_EXP);

    // fill to the ready threshold with the output stalled, then drain
    out_if.tready = 1'b0;
    push(16'h000F, w4(32'h100, 32'h0, 32'h0, 32'h0), 1'b0);
    chk("full_fill1", fill, 1);
    push(16'hFFFF, w4(32'h101, 32'h102, 32'h103, 32'h104), 1'b0);
    chk("full_fill5", fill, 5);
    chk("full_win_tvalid", out_if.tvalid, 1'b1);
    chk("full_win_data", out_if.tdata, {exp_q[1], exp_q[0]});
    push(16'hFFFF, w4(32'h105, 32'h106, 32'h107, 32'h108), 1'b0);
    chk("full_fill9", fill, 9);
    chk("full_ready_at9", in_if.tready, 1'b1);
    push(16'hFFFF, w4(32'h109, 32'h10A, 32'h10B, 32'h10C), 1'b0);
    chk("full_fill13", fill, 13);
    chk("full_ready_at13", in_if.tready, 1'b0);
    chk("full_win_stable", out_if.tdata, {exp_q[1], exp_q[0]});
    in_if.tdata  = w4(32'hBAD0, 32'hBAD1, 32'hBAD2, 32'hBAD3);
    in_if.tkeep  = 16'hFFFF;
    in_if.tvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("full_no_accept", fill, 13);
    in_if.tvalid  = 1'b0;
    in_if.tkeep   = '0;
    out_if.tready = 1'b1;
    drain(10);
    chk("full_residual_fill", fill, 1);
    chk("full_residual_q", exp_q.size(), 1);
    push(16'h000F, w4(32'h200, 32'h0, 32'h0, 32'h0), 1'b1);
    drain(4);
    chk("full_drained_q", exp_q.size(), 0);
    chk("full_drained_fill", fill, 0);

    // simultaneous push of 3 and pop of 2 at count 5
    out_if.tready = 1'b0;
    push(16'hFFFF, w4(32'h300, 32'h301, 32'h302, 32'h303), 1'b0);
    push(16'h000F, w4(32'h304, 32'h0, 32'h0, 32'h0), 1'b0);
    chk("simul_fill5", fill, 5);
    out_if.tready = 1'b1;
    in_if.tdata   = w4(32'h305, 32'h306, 32'h307, 32'h0);
    in_if.tkeep   = 16'h0FFF;
    in_if.tvalid  = 1'b1;
    chk("simul_pop_data", out_if.tdata, {exp_q[1], exp_q[0]});
    @(negedge clk);
    in_if.tvalid  = 1'b0;
    in_if.tkeep   = '0;
    out_if.tready = 1'b0;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    add_exp(16'h0FFF, w4(32'h305, 32'h306, 32'h307, 32'h0));
    chk("simul_fill6", fill, 6);
    out_if.tready = 1'b1;
    drain(6);
    chk("simul_drained_q", exp_q.size(), 0);
    chk("simul_drained_fill", fill, 0);

    // reset mid-packet at count 7
    out_if.tready = 1'b0;
    push(16'h0000, w4(32'h0, 32'h0, 32'h0, 32'h0), 1'b1);
    chk("mid_err_set", err, ERR_EXP);
    push(16'hFFFF, w4(32'h400, 32'h401, 32'h402, 32'h403), 1'b0);
    push(16'h0FFF, w4(32'h404, 32'h405, 32'h406, 32'h0), 1'b0);
    chk("mid_fill7", fill, 7);
    chk("mid_tvalid_before", out_if.tvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_fill", fill, 0);
    chk("mid_rst_tvalid", out_if.tvalid, 1'b0);
    chk("mid_rst_tkeep", out_if.tkeep, 8'h00);
    chk("mid_rst_tready", in_if.tready, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    out_if.tready = 1'b1;
    push(16'h00FF, w4(32'h500, 32'h501, 32'h0, 32'h0), 1'b1);
    chk("post_mid_tdata", out_if.tdata, {32'h501, 32'h500});
    chk("post_mid_tlast", out_if.tlast, 1'b1);
    drain(4);
    chk("post_mid_q", exp_q.size(), 0);
    chk("post_mid_fill", fill, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
